// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data RAM arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_EXT  = 1'b1;

  // Access size/sign codes, identical to the load/store funct3 field seen by the RAM
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  typedef struct packed {
    logic                  we;
    logic [2:0]            ctrl;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that did not own the previous access.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] grant
);

  assign grant[0] = req[0] & (~req[1] | (last_owner == PORT_EXT));
  assign grant[1] = req[1] & (~req[0] | (last_owner == PORT_CORE));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data RAM between the core load/store path (port 0) and the
// external loader/debug port (port 1); one access in flight, round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [2:0]        c_ctrl,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              x_req,
  input  logic              x_we,
  input  logic [2:0]        x_ctrl,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              x_gnt,
  output logic              x_rvalid,
  output logic [DATA_W-1:0] x_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [2:0]        m_ctrl,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_e            state;
  logic [2:0]        cnt;
  logic              last_owner;
  logic              owner;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] x_rdata_q;
  logic [1:0]        pick;
  logic [1:0]        grant;
  logic              rd_done;
  logic              arb_open;
  logic              core_rd_pend;
  req_t              c_pkt;
  req_t              x_pkt;
  req_t              sel;

  assign rd_done = (state == RD_WAIT) && (cnt == 3'd0);

  // Grants are combinational, so they are also gated by nReset to keep every
  // output at 0 for the whole time reset is held.
  assign arb_open = nReset && ((state == IDLE) || rd_done);

  rr_pick2 u_pick (
    .req        ({x_req, c_req}),
    .last_owner (last_owner),
    .grant      (pick)
  );

  assign grant = arb_open ? pick : 2'b00;
  assign c_gnt = grant[0];
  assign x_gnt = grant[1];
  assign m_en  = |grant;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    c_pkt = '{we: c_we, ctrl: c_ctrl, addr: REQ_ADDR_W'(c_addr), wdata: REQ_DATA_W'(c_wdata)};
    x_pkt = '{we: x_we, ctrl: x_ctrl, addr: REQ_ADDR_W'(x_addr), wdata: REQ_DATA_W'(x_wdata)};
    sel   = '0;
    if (grant[1])      sel = x_pkt;
    else if (grant[0]) sel = c_pkt;
  end

  assign m_we    = sel.we;
  assign m_ctrl  = sel.ctrl;
  assign m_addr  = sel.addr[ADDR_W-1:0];
  assign m_wdata = sel.wdata[DATA_W-1:0];

  assign c_rvalid = rd_done && (owner == PORT_CORE);
  assign x_rvalid = rd_done && (owner == PORT_EXT);
  assign c_rdata  = c_rvalid ? m_rdata : c_rdata_q;
  assign x_rdata  = x_rvalid ? m_rdata : x_rdata_q;

  // A core read counts as outstanding from its grant cycle until its rvalid.
  assign core_rd_pend = (c_gnt && !c_we) ||
                        ((state == RD_WAIT) && (owner == PORT_CORE) && !c_rvalid);
  assign c_stall      = (nReset && c_req && !c_gnt) || core_rd_pend;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      last_owner <= PORT_EXT;
      owner      <= PORT_CORE;
      c_rdata_q  <= '0;
      x_rdata_q  <= '0;
    end else begin
      if (c_rvalid) c_rdata_q <= m_rdata;
      if (x_rvalid) x_rdata_q <= m_rdata;

      if (m_en) begin
        last_owner <= grant[1];
        if (!sel.we) begin
          state <= RD_WAIT;
          cnt   <= LAT_LOAD;
          owner <= grant[1];
        end else begin
          state <= IDLE;
        end
      end else if (state == RD_WAIT) begin
        if (rd_done) state <= IDLE;
        else         cnt   <= cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: two arbiters (RD_LAT 1 and 3) share stimulus, each with
// its own RAM model and a read scoreboard.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          c_req, c_we, x_req, x_we;
  logic [2:0]    c_ctrl, x_ctrl;
  logic [AW-1:0] c_addr, x_addr;
  logic [DW-1:0] c_wdata, x_wdata;

  logic [1:0]          c_gnt, c_rvalid, c_stall, x_gnt, x_rvalid, m_en, m_we;
  logic [1:0][DW-1:0]  c_rdata, x_rdata, m_wdata, m_rdata;
  logic [1:0][2:0]     m_ctrl;
  logic [1:0][AW-1:0]  m_addr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
      .Clock    (clk),
      .nReset   (rst_n),
      .c_req    (c_req),
      .c_we     (c_we),
      .c_ctrl   (c_ctrl),
      .c_addr   (c_addr),
      .c_wdata  (c_wdata),
      .c_gnt    (c_gnt[g]),
      .c_rvalid (c_rvalid[g]),
      .c_rdata  (c_rdata[g]),
      .c_stall  (c_stall[g]),
      .x_req    (x_req),
      .x_we     (x_we),
      .x_ctrl   (x_ctrl),
      .x_addr   (x_addr),
      .x_wdata  (x_wdata),
      .x_gnt    (x_gnt[g]),
      .x_rvalid (x_rvalid[g]),
      .x_rdata  (x_rdata[g]),
      .m_en     (m_en[g]),
      .m_we     (m_we[g]),
      .m_ctrl   (m_ctrl[g]),
      .m_addr   (m_addr[g]),
      .m_wdata  (m_wdata[g]),
      .m_rdata  (m_rdata[g])
    );

    // RAM model: word array plus an LAT-deep read pipeline (0 when idle)
    logic [DW-1:0] ram  [64];
    logic [DW-1:0] pipe [LAT];
    exp_t          sb [$];
    exp_t          e;

    initial begin
      for (int i = 0; i < 64; i++) ram[i] = '0;
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
      ram[8] = 32'h1234_5678;
    end

    always @(posedge clk) begin
      if (m_en[g] && m_we[g]) ram[m_addr[g][7:2]] <= m_wdata[g];
      pipe[0] <= (m_en[g] && !m_we[g]) ? ram[m_addr[g][7:2]] : '0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign m_rdata[g] = pipe[LAT-1];

    always @(negedge clk) begin
      if (!rst_n) begin
        sb.delete();
      end else begin
        if (c_rvalid[g] || x_rvalid[g]) begin
          if (sb.size() == 0) begin
            check($sformatf("d%0d_stray_rvalid", g), 1'b1, 1'b0);
          end else begin
            e = sb.pop_front();
            check($sformatf("d%0d_rv_port", g), x_rvalid[g], e.port);
            check($sformatf("d%0d_rv_data", g), x_rvalid[g] ? x_rdata[g] : c_rdata[g], e.data);
            check($sformatf("d%0d_rv_cycle", g), cyc, e.due);
          end
        end else if (sb.size() != 0 && cyc >= sb[0].due) begin
          check($sformatf("d%0d_rv_missing", g), 1'b0, 1'b1);
          void'(sb.pop_front());
        end
        if ((c_gnt[g] || x_gnt[g]) && !m_we[g])
          sb.push_back('{port: x_gnt[g], data: ram[m_addr[g][7:2]], due: cyc + LAT});
      end
    end
  end

  function automatic logic outs_or();
    return |{c_gnt, c_rvalid, c_stall, x_gnt, x_rvalid, m_en, m_we,
             m_ctrl, m_addr, m_wdata, c_rdata, x_rdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_c(input logic req, input logic we, input logic [2:0] ctrl,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    c_req = req; c_we = we; c_ctrl = ctrl; c_addr = addr; c_wdata = wdata;
  endtask

  task automatic drive_x(input logic req, input logic we, input logic [2:0] ctrl,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    x_req = req; x_we = we; x_ctrl = ctrl; x_addr = addr; x_wdata = wdata;
  endtask

  initial begin
    drive_c(0, 0, 3'd0, '0, '0);
    drive_x(0, 0, 3'd0, '0, '0);
    rst_n = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", outs_or(), 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outs", outs_or(), 1'b0);
      tick();
    end

    // Core write 0xDEADBEEF to 0x10
    drive_c(1, 1, F3_SW, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("d%0d_w_cgnt", g), c_gnt[g], 1'b1);
      check($sformatf("d%0d_w_men", g), m_en[g], 1'b1);
      check($sformatf("d%0d_w_mwe", g), m_we[g], 1'b1);
      check($sformatf("d%0d_w_maddr", g), m_addr[g], 32'h10);
      check($sformatf("d%0d_w_mwdata", g), m_wdata[g], 32'hDEAD_BEEF);
      check($sformatf("d%0d_w_mctrl", g), m_ctrl[g], F3_SW);
      check($sformatf("d%0d_w_stall", g), c_stall[g], 1'b0);
      check($sformatf("d%0d_w_xgnt", g), x_gnt[g], 1'b0);
    end
    tick();
    drive_c(0, 0, 3'd0, '0, '0);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("d%0d_w_after_men", g), m_en[g], 1'b0);
      check($sformatf("d%0d_w_after_maddr", g), m_addr[g], 32'h0);
      check($sformatf("d%0d_w_after_stall", g), c_stall[g], 1'b0);
    end

    // Core read of 0x10
    tick();
    drive_c(1, 0, F3_LW, 32'h10, '0);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("d%0d_r_cgnt", g), c_gnt[g], 1'b1);
      check($sformatf("d%0d_r_mwe", g), m_we[g], 1'b0);
      check($sformatf("d%0d_r_stall0", g), c_stall[g], 1'b1);
    end
    tick();
    drive_c(0, 0, 3'd0, '0, '0);
    @(negedge clk);
    check("d0_r_rvalid1", c_rvalid[0], 1'b1);
    check("d0_r_rdata1", c_rdata[0], 32'hDEAD_BEEF);
    check("d0_r_stall1", c_stall[0], 1'b0);
    check("d1_r_rvalid1", c_rvalid[1], 1'b0);
    check("d1_r_stall1", c_stall[1], 1'b1);
    tick();
    @(negedge clk);
    check("d1_r_stall2", c_stall[1], 1'b1);
    check("d1_r_men2", m_en[1], 1'b0);
    tick();
    @(negedge clk);
    check("d1_r_rvalid3", c_rvalid[1], 1'b1);
    check("d1_r_stall3", c_stall[1], 1'b0);
    tick();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("d%0d_r_hold", g), c_rdata[g], 32'hDEAD_BEEF);
      check($sformatf("d%0d_r_rv_low", g), c_rvalid[g], 1'b0);
    end

    // Fresh reset, then continuous contention with writes
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_outs", outs_or(), 1'b0);
    tick();
    rst_n = 1'b1;
    drive_c(1, 1, F3_SW, 32'h30, 32'hA5A5_0001);
    drive_x(1, 1, F3_SW, 32'h34, 32'h5A5A_0002);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        check($sformatf("d%0d_rr%0d_cgnt", g, i), c_gnt[g], (i % 2) == 0);
        check($sformatf("d%0d_rr%0d_xgnt", g, i), x_gnt[g], (i % 2) == 1);
        check($sformatf("d%0d_rr%0d_stall", g, i), c_stall[g], (i % 2) == 1);
        check($sformatf("d%0d_rr%0d_maddr", g, i), m_addr[g], ((i % 2) == 0) ? 32'h30 : 32'h34);
      end
      tick();
    end
    drive_c(0, 0, 3'd0, '0, '0);
    drive_x(0, 0, 3'd0, '0, '0);

    // Ext read of 0x20, core write waiting behind it
    drive_x(1, 0, F3_LW, 32'h20, '0);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("d%0d_x_xgnt", g), x_gnt[g], 1'b1);
      check($sformatf("d%0d_x_maddr", g), m_addr[g], 32'h20);
    end
    tick();
    drive_x(0, 0, 3'd0, '0, '0);
    drive_c(1, 1, F3_SW, 32'h38, 32'h0BAD_F00D);
    @(negedge clk);
    check("d0_x_rvalid1", x_rvalid[0], 1'b1);
    check("d0_x_rdata1", x_rdata[0], 32'h1234_5678);
    check("d0_x_b2b_cgnt", c_gnt[0], 1'b1);
    check("d1_x_wait1_cgnt", c_gnt[1], 1'b0);
    check("d1_x_wait1_men", m_en[1], 1'b0);
    check("d1_x_wait1_stall", c_stall[1], 1'b1);
    tick();
    @(negedge clk);
    check("d1_x_wait2_men", m_en[1], 1'b0);
    check("d1_x_wait2_stall", c_stall[1], 1'b1);
    tick();
    @(negedge clk);
    check("d1_x_rvalid3", x_rvalid[1], 1'b1);
    check("d1_x_rdata3", x_rdata[1], 32'h1234_5678);
    check("d1_x_b2b_cgnt", c_gnt[1], 1'b1);
    check("d1_x_b2b_mwe", m_we[1], 1'b1);
    check("d1_x_b2b_stall", c_stall[1], 1'b0);
    check("d1_x_crdata_kept", c_rdata[1], 32'h0);
    tick();
    drive_c(0, 0, 3'd0, '0, '0);

    // Reset while a core read is in flight
    drive_c(1, 0, F3_LW, 32'h34, '0);
    @(negedge clk);
    for (int g = 0; g < 2; g++) check($sformatf("d%0d_rr_cgnt", g), c_gnt[g], 1'b1);
    tick();
    drive_c(0, 0, 3'd0, '0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_outs", outs_or(), 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_quiet", |{c_rvalid, x_rvalid, c_stall}, 1'b0);
      tick();
    end
    drive_c(1, 1, F3_SW, 32'h3C, 32'h1);
    drive_x(1, 1, F3_SW, 32'h3C, 32'h2);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("d%0d_post_rst_cgnt", g), c_gnt[g], 1'b1);
      check($sformatf("d%0d_post_rst_xgnt", g), x_gnt[g], 1'b0);
    end
    tick();
    drive_c(0, 0, 3'd0, '0, '0);
    @(negedge clk);
    for (int g = 0; g < 2; g++) check($sformatf("d%0d_post_rst_xturn", g), x_gnt[g], 1'b1);
    tick();
    drive_x(0, 0, 3'd0, '0, '0);

    repeat (5) tick();
    check("d0_sb_empty", g_dut[0].sb.size(), 0);
    check("d1_sb_empty", g_dut[1].sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
